// File: rtl/bcd_to_binary_if.sv
// Request/result bundle for the BCD-to-binary converter.
// The master starts requests and reads results; the slave is the converter.
interface bcd_to_binary_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start,
    output bcd_in,
    input  binary,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  bcd_in,
    output binary,
    output busy,
    output done,
    output error
  );

endinterface

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double dabble).
// One right shift plus per-digit subtract-3 correction per clock; requests
// containing a digit above 9 are flagged as errors instead of converted.
// 10^DIGITS-1 must fit in BIN_W bits for results to be meaningful.
module bcd_to_binary #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic          clk,
  input  logic          rst,
  bcd_to_binary_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t            state_q;
  logic [SH_W-1:0]   sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bad_q;
  logic [BIN_W-1:0]  binary_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic [SH_W-1:0]   shifted;
  logic [SH_W-1:0]   shift_d;
  logic              anyBad_d;

  // One reverse double dabble step: shift right, then pull each BCD digit
  // that landed at 8 or more back down by 3 (digits never borrow from each other).
  always_comb begin
    shifted = sh_q >> 1;
    shift_d = shifted;
    for (int k = 0; k < DIGITS; k++) begin
      if (shifted[BIN_W + 4*k +: 4] >= 4'd8) begin
        shift_d[BIN_W + 4*k +: 4] = shifted[BIN_W + 4*k +: 4] - 4'd3;
      end
    end
  end

  // Flag a request whose incoming digits are not all legal decimal digits.
  always_comb begin
    anyBad_d = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bus.bcd_in[4*k +: 4] > 4'd9) begin
        anyBad_d = 1'b1;
      end
    end
  end

  // Control FSM owning the working register, counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      binary_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sh_q    <= {bus.bcd_in, {BIN_W{1'b0}}};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            bad_q   <= anyBad_d;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          if (bad_q) begin
            state_q <= DONE;
          end else begin
            sh_q  <= shift_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (bad_q) begin
            error_q <= 1'b1;
          end else begin
            binary_q <= sh_q[BIN_W-1:0];
            error_q  <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.binary = binary_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: a 2-digit/7-bit instance and a
// 3-digit/10-bit instance, checked against a plain-arithmetic decimal model.
module tb_bcd_to_binary;

  logic clk;
  logic rst;

  int nChecks;
  int nBad;
  int modelBin[2];

  bcd_to_binary_if #(.DIGITS(2), .BIN_W(7))  busA ();
  bcd_to_binary_if #(.DIGITS(3), .BIN_W(10)) busB ();

  bcd_to_binary #(.DIGITS(2), .BIN_W(7)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  bcd_to_binary #(.DIGITS(3), .BIN_W(10)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Decimal value of the packed digits, by ordinary positional arithmetic.
  function automatic int refValue(input logic [11:0] bcd, input int digits);
    int v, p;
    v = 0;
    p = 1;
    for (int k = 0; k < digits; k++) begin
      v = v + int'(bcd[4*k +: 4]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic logic refBad(input logic [11:0] bcd, input int digits);
    for (int k = 0; k < digits; k++) begin
      if (int'(bcd[4*k +: 4]) > 9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic doneOf(input int which);
    return (which != 0) ? busB.done : busA.done;
  endfunction

  function automatic logic busyOf(input int which);
    return (which != 0) ? busB.busy : busA.busy;
  endfunction

  function automatic logic errOf(input int which);
    return (which != 0) ? busB.error : busA.error;
  endfunction

  function automatic int binOf(input int which);
    return (which != 0) ? int'(busB.binary) : int'(busA.binary);
  endfunction

  task automatic driveReq(input int which, input logic s, input logic [11:0] bcd);
    if (which != 0) begin
      busB.start  = s;
      busB.bcd_in = bcd;
    end else begin
      busA.start  = s;
      busA.bcd_in = bcd[7:0];
    end
  endtask

  // One start pulse, then follow the request to done and check every output.
  task automatic applyStimulus(input int which, input logic [11:0] bcd, input string tag);
    int n, busyCnt, expLat, digits, binW, value;
    logic isBad;
    digits = (which != 0) ? 3 : 2;
    binW   = (which != 0) ? 10 : 7;
    value  = refValue(bcd, digits);
    isBad  = refBad(bcd, digits);
    expLat = isBad ? 2 : binW + 1;
    @(negedge clk);
    driveReq(which, 1'b1, bcd);
    @(posedge clk);
    @(negedge clk);
    driveReq(which, 1'b0, 12'($urandom));
    n = 0;
    busyCnt = 0;
    while (!doneOf(which) && n < 40) begin
      if (busyOf(which)) busyCnt++;
      @(negedge clk);
      n++;
    end
    if (!isBad) modelBin[which] = value;
    checkOutput({tag, " latency"}, n, expLat);
    checkOutput({tag, " busy cycles"}, busyCnt, expLat);
    checkOutput({tag, " binary"}, binOf(which), modelBin[which]);
    checkOutput({tag, " error"}, errOf(which), isBad);
    checkOutput({tag, " busy at done"}, busyOf(which), 0);
    @(negedge clk);
    checkOutput({tag, " done single pulse"}, doneOf(which), 0);
  endtask

  initial begin
    int doneCnt, doneAt, doneBin, firstDone, secondDone, bin1, bin2;
    logic [11:0] r;
    nChecks = 0;
    nBad = 0;
    modelBin[0] = 0;
    modelBin[1] = 0;
    busA.start = 1'b0;
    busA.bcd_in = '0;
    busB.start = 1'b0;
    busB.bcd_in = '0;
    rst = 1'b1;

    #12;
    checkOutput("reset binary", binOf(0), 0);
    checkOutput("reset busy", busyOf(0), 0);
    checkOutput("reset done", doneOf(0), 0);
    checkOutput("reset error", errOf(0), 0);
    checkOutput("reset B binary", binOf(1), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] convert 99 and full sweep");
    applyStimulus(0, 12'h099, "bcd 99");
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        applyStimulus(0, {4'd0, 4'(t), 4'(o)}, "sweep");
      end
    end

    $display("[TB] invalid digit handling");
    applyStimulus(0, 12'h042, "bcd 42");
    applyStimulus(0, 12'h03A, "bcd 3A");
    applyStimulus(0, 12'h007, "bcd 07");

    $display("[TB] start ignored while busy");
    @(negedge clk);
    driveReq(0, 1'b1, 12'h025);
    doneCnt = 0;
    doneAt = -1;
    doneBin = -1;
    for (int n = 0; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 0) driveReq(0, 1'b0, 12'h061);
      if (n == 2) driveReq(0, 1'b1, 12'h061);
      if (n == 3) driveReq(0, 1'b0, 12'h061);
      if (busA.done) begin
        doneCnt++;
        doneAt = n;
        doneBin = binOf(0);
      end
    end
    modelBin[0] = 25;
    checkOutput("ignored start done count", doneCnt, 1);
    checkOutput("ignored start done edge", doneAt, 8);
    checkOutput("ignored start binary", doneBin, 25);

    $display("[TB] held start back-to-back");
    @(negedge clk);
    driveReq(0, 1'b1, 12'h037);
    firstDone = -1;
    secondDone = -1;
    bin1 = -1;
    bin2 = -1;
    for (int n = 0; n <= 17; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 0) driveReq(0, 1'b1, 12'h058);
      if (busA.done) begin
        if (firstDone < 0) begin
          firstDone = n;
          bin1 = binOf(0);
        end else begin
          secondDone = n;
          bin2 = binOf(0);
        end
      end
    end
    driveReq(0, 1'b0, 12'h000);
    modelBin[0] = 58;
    checkOutput("held first done edge", firstDone, 8);
    checkOutput("held done spacing", secondDone - firstDone, 9);
    checkOutput("held first binary", bin1, 37);
    checkOutput("held second binary", bin2, 58);
    @(negedge clk);

    $display("[TB] random requests on 2-digit instance");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(0, 12'($urandom_range(0, 255)), "random A");
    end

    $display("[TB] 3-digit instance");
    applyStimulus(1, 12'h999, "B 999");
    applyStimulus(1, 12'h000, "B 000");
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else r = 12'($urandom);
      applyStimulus(1, r, "random B");
    end
    applyStimulus(1, 12'h512, "B 512");

    $display("[TB] reset mid-conversion");
    @(negedge clk);
    driveReq(0, 1'b1, 12'h088);
    @(posedge clk);
    @(negedge clk);
    driveReq(0, 1'b0, 12'h000);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    modelBin[0] = 0;
    modelBin[1] = 0;
    checkOutput("mid reset binary", binOf(0), 0);
    checkOutput("mid reset busy", busyOf(0), 0);
    checkOutput("mid reset done", doneOf(0), 0);
    checkOutput("mid reset error", errOf(0), 0);
    checkOutput("mid reset B binary", binOf(1), 0);
    @(negedge clk);
    rst = 1'b0;
    doneCnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (busA.done) doneCnt++;
    end
    checkOutput("no done after reset", doneCnt, 0);
    applyStimulus(0, 12'h013, "after reset 13");
    applyStimulus(1, 12'h512, "after reset B 512");

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
